// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [7:0]  WAIT_LIMIT = 8'd255;
  localparam logic [15:0] STALL_MAX  = 16'hFFFF;

  // One in-flight register write: which rd it targets and whether it is real.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: REG_ZERO};

  // True when an in-flight write targets the given source register.
  function automatic logic entry_match(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && (e.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its controller.
interface pipeline_ctrl_if;

  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_reg_wen;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [15:0] stall_cnt;
  logic        mem_timeout;
  logic        busy_wait;

  // Datapath side: reports stage status, consumes enables and flushes.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_reg_wen, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, stall_cnt, mem_timeout, busy_wait
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_wen, ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, stall_cnt, mem_timeout, busy_wait
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// Tracks destination registers in EX/MEM/WB and flags read-after-write hazards
// for the instruction sitting in ID. WB is included because the register file
// does not forward a same-cycle write to its read ports.
module hazard_scoreboard
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       branch_taken,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_reg_wen,
  output logic       hazard
);

  sb_entry_t sb_ex;
  sb_entry_t sb_mem;
  sb_entry_t sb_wb;
  logic      rs1_hit;
  logic      rs2_hit;
  logic      push;

  // Match ID sources against every in-flight write; x0 never creates a dependency.
  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1 != REG_ZERO) &&
              (entry_match(sb_ex, id_rs1) || entry_match(sb_mem, id_rs1) ||
               entry_match(sb_wb, id_rs1));
    rs2_hit = id_rs2_used && (id_rs2 != REG_ZERO) &&
              (entry_match(sb_ex, id_rs2) || entry_match(sb_mem, id_rs2) ||
               entry_match(sb_wb, id_rs2));
    hazard  = id_valid && (rs1_hit || rs2_hit);
    push    = id_valid && id_reg_wen && (id_rd != REG_ZERO) && !hazard && !branch_taken;
  end

  // Shift the write tracker along with the pipeline; hold it while memory is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_ex  <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
      sb_wb  <= SB_EMPTY;
    end else if (advance) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= push ? '{valid: 1'b1, rd: id_rd} : SB_EMPTY;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage enables/flushes, memory-wait FSM with
// watchdog, and a saturating count of cycles in which the PC did not advance.
module pipeline_ctrl
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       freeze;
  logic       hazard;

  assign freeze = bus.mem_req & ~bus.mem_ready;

  hazard_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .advance      (~freeze),
    .branch_taken (bus.ex_branch_taken),
    .id_valid     (bus.id_valid),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .id_rs1_used  (bus.id_rs1_used),
    .id_rs2_used  (bus.id_rs2_used),
    .id_rd        (bus.id_rd),
    .id_reg_wen   (bus.id_reg_wen),
    .hazard       (hazard)
  );

  // Stage control with priority freeze > branch > hazard > run; a branch seen
  // during a freeze simply waits for the release cycle.
  always_comb begin
    bus.pc_en       = 1'b1;
    bus.if_id_en    = 1'b1;
    bus.id_ex_en    = 1'b1;
    bus.ex_mem_en   = 1'b1;
    bus.mem_wb_en   = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    if (reset) begin
      bus.pc_en = 1'b1;
    end else if (freeze) begin
      bus.pc_en     = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.id_ex_en  = 1'b0;
      bus.ex_mem_en = 1'b0;
      bus.mem_wb_en = 1'b0;
    end else if (bus.ex_branch_taken) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (hazard) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  // Memory-wait FSM with a watchdog that latches once a wait runs 255 cycles past entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_RUN;
      bus.busy_wait   <= 1'b0;
      wait_cnt        <= '0;
      bus.mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (freeze) begin
            state         <= ST_MEM_WAIT;
            bus.busy_wait <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!freeze) begin
            state         <= ST_RUN;
            bus.busy_wait <= 1'b0;
            wait_cnt      <= '0;
          end else begin
            if (wait_cnt != WAIT_LIMIT) begin
              wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_cnt == WAIT_LIMIT - 8'd1) begin
              bus.mem_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state         <= ST_RUN;
          bus.busy_wait <= 1'b0;
          wait_cnt      <= '0;
        end
      endcase
    end
  end

  // Count every cycle the PC is held, saturating rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stall_cnt <= '0;
    end else if (!bus.pc_en && (bus.stall_cnt != STALL_MAX)) begin
      bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic checked
// against a register-availability model (cycles until each register is readable).
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pending[r] = edges remaining until register r is safe to read.
  int pending[32];
  int stall_model;
  int run_len;
  bit busy_model;
  bit timeout_model;

  logic [6:0] ctl_act;
  assign ctl_act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                    bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush};

  task automatic drive_idle();
    bus.id_valid        = 1'b0;
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.id_rs1_used     = 1'b0;
    bus.id_rs2_used     = 1'b0;
    bus.id_rd           = 5'd0;
    bus.id_reg_wen      = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic wen);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_reg_wen  = wen;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) pending[r] = 0;
    stall_model   = 0;
    run_len       = 0;
    busy_model    = 1'b0;
    timeout_model = 1'b0;
  endtask

  function automatic logic model_hazard();
    logic h1;
    logic h2;
    h1 = bus.id_rs1_used && (bus.id_rs1 != 5'd0) && (pending[bus.id_rs1] > 0);
    h2 = bus.id_rs2_used && (bus.id_rs2 != 5'd0) && (pending[bus.id_rs2] > 0);
    return bus.id_valid && (h1 || h2);
  endfunction

  // Expected {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}.
  function automatic logic [6:0] model_ctl();
    if (reset) return 7'b1111100;
    if (bus.mem_req && !bus.mem_ready) return 7'b0000000;
    if (bus.ex_branch_taken) return 7'b1111111;
    if (model_hazard()) return 7'b0011101;
    return 7'b1111100;
  endfunction

  // Advance one clock and let the model retire/issue writes for that edge.
  task automatic clock_edge();
    logic [6:0] ctl;
    logic       hz;
    logic       frz;
    @(posedge clk);
    if (!reset) begin
      ctl = model_ctl();
      hz  = model_hazard();
      frz = bus.mem_req && !bus.mem_ready;
      if (!frz) begin
        for (int r = 0; r < 32; r++) if (pending[r] > 0) pending[r]--;
        if (bus.id_valid && bus.id_reg_wen && (bus.id_rd != 5'd0) && !hz && !bus.ex_branch_taken)
          pending[bus.id_rd] = 3;
      end
      if (!ctl[6] && stall_model < 65535) stall_model++;
      busy_model = frz;
      run_len = frz ? run_len + 1 : 0;
      if (run_len >= 256) timeout_model = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    model_clear();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    bus.mem_req = 1'b1;
    bus.ex_branch_taken = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (ctl_act !== 7'b1111100) begin
      errors++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl_act, 7'b1111100);
    end
    checks++;
    if (bus.busy_wait !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_wait);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", bus.stall_cnt);
    end
    checks++;
    if (bus.mem_timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.mem_timeout);
    end
    drive_idle();
    model_clear();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl_act !== 7'b1111100) begin
      errors++; $display("[TB] FAIL reset_run_ctl: got %b expected %b", ctl_act, 7'b1111100);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl_act !== 7'b1111100) begin
      errors++; $display("[TB] FAIL load_use_issue: got %b expected %b", ctl_act, 7'b1111100);
    end
    clock_edge();
    drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl_act !== 7'b0011101) begin
        errors++; $display("[TB] FAIL load_use_stall cycle %0d: got %b expected %b", i, ctl_act, 7'b0011101);
      end
      clock_edge();
    end
    @(negedge clk);
    checks++;
    if (ctl_act !== 7'b1111100) begin
      errors++; $display("[TB] FAIL load_use_release: got %b expected %b", ctl_act, 7'b1111100);
    end
    checks++;
    if (bus.stall_cnt !== 16'd3) begin
      errors++; $display("[TB] FAIL load_use_stall_cnt: got %0d expected 3", bus.stall_cnt);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    clock_edge();
    @(negedge clk);
    checks++;
    if (dut.u_scoreboard.sb_ex.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL x0_ex_valid: got %b expected 0", dut.u_scoreboard.sb_ex.valid);
    end
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    #1;
    checks++;
    if (ctl_act !== 7'b1111100) begin
      errors++; $display("[TB] FAIL x0_read: got %b expected %b", ctl_act, 7'b1111100);
    end
    clock_edge();
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL x0_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
    clock_edge();
    drive_id(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0);
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl_act !== 7'b1111111) begin
      errors++; $display("[TB] FAIL branch_over_hazard: got %b expected %b", ctl_act, 7'b1111111);
    end
    bus.ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (ctl_act !== 7'b0011101) begin
      errors++; $display("[TB] FAIL hazard_without_branch: got %b expected %b", ctl_act, 7'b0011101);
    end
    clock_edge();
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1);
    clock_edge();
    drive_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.ex_branch_taken = (c == 2 || c == 3);
      @(negedge clk);
      checks++;
      if (ctl_act !== 7'b0000000) begin
        errors++; $display("[TB] FAIL mem_wait_ctl cycle %0d: got %b expected 0000000", c, ctl_act);
      end
      checks++;
      if (bus.busy_wait !== (c >= 2)) begin
        errors++; $display("[TB] FAIL mem_wait_busy cycle %0d: got %b expected %b", c, bus.busy_wait, (c >= 2));
      end
      clock_edge();
    end
    bus.ex_branch_taken = 1'b0;
    bus.mem_ready = 1'b1;
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (ctl_act !== ((c <= 7) ? 7'b0011101 : 7'b1111100)) begin
        errors++; $display("[TB] FAIL mem_wait_release cycle %0d: got %b expected %b", c, ctl_act,
                           ((c <= 7) ? 7'b0011101 : 7'b1111100));
      end
      checks++;
      if (bus.busy_wait !== (c == 5)) begin
        errors++; $display("[TB] FAIL mem_wait_busy cycle %0d: got %b expected %b", c, bus.busy_wait, (c == 5));
      end
      clock_edge();
      bus.mem_req = 1'b0;
      bus.mem_ready = 1'b0;
    end
    checks++;
    if (bus.stall_cnt !== 16'd7) begin
      errors++; $display("[TB] FAIL mem_wait_stall_cnt: got %0d expected 7", bus.stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_ctl;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.id_valid        = ($urandom_range(3) != 0);
      bus.id_rs1          = 5'($urandom_range(3));
      bus.id_rs2          = 5'($urandom_range(3));
      bus.id_rs1_used     = 1'($urandom_range(1));
      bus.id_rs2_used     = 1'($urandom_range(1));
      bus.id_rd           = 5'($urandom_range(3));
      bus.id_reg_wen      = 1'($urandom_range(1));
      bus.ex_branch_taken = ($urandom_range(7) == 0);
      bus.mem_req         = ($urandom_range(2) == 0);
      bus.mem_ready       = 1'($urandom_range(1));
      @(negedge clk);
      exp_ctl = model_ctl();
      checks++;
      if (ctl_act !== exp_ctl) begin
        errors++; $display("[TB] FAIL random_ctl step %0d: got %b expected %b", n, ctl_act, exp_ctl);
      end
      checks++;
      if (bus.stall_cnt !== 16'(stall_model)) begin
        errors++; $display("[TB] FAIL random_stall step %0d: got %0d expected %0d", n, bus.stall_cnt, stall_model);
      end
      checks++;
      if (bus.busy_wait !== busy_model) begin
        errors++; $display("[TB] FAIL random_busy step %0d: got %b expected %b", n, bus.busy_wait, busy_model);
      end
      checks++;
      if (bus.mem_timeout !== timeout_model) begin
        errors++; $display("[TB] FAIL random_timeout step %0d: got %b expected %b", n, bus.mem_timeout, timeout_model);
      end
      clock_edge();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 255; i++) clock_edge();
    @(negedge clk);
    checks++;
    if (bus.mem_timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL watchdog_early: got %b expected 0", bus.mem_timeout);
    end
    clock_edge();
    @(negedge clk);
    checks++;
    if (bus.mem_timeout !== 1'b1) begin
      errors++; $display("[TB] FAIL watchdog_fire: got %b expected 1", bus.mem_timeout);
    end
    bus.mem_ready = 1'b1;
    clock_edge();
    bus.mem_req = 1'b0;
    for (int i = 0; i < 3; i++) clock_edge();
    @(negedge clk);
    checks++;
    if (bus.mem_timeout !== 1'b1) begin
      errors++; $display("[TB] FAIL watchdog_sticky: got %b expected 1", bus.mem_timeout);
    end
    checks++;
    if (bus.busy_wait !== 1'b0) begin
      errors++; $display("[TB] FAIL watchdog_release_busy: got %b expected 0", bus.busy_wait);
    end
  endtask

  task automatic test_async_reset();
    drive_idle();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) clock_edge();
    @(negedge clk);
    checks++;
    if (bus.busy_wait !== 1'b1) begin
      errors++; $display("[TB] FAIL async_pre_busy: got %b expected 1", bus.busy_wait);
    end
    checks++;
    if (bus.stall_cnt !== 16'(stall_model)) begin
      errors++; $display("[TB] FAIL async_pre_stall: got %0d expected %0d", bus.stall_cnt, stall_model);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy_wait !== 1'b0) begin
      errors++; $display("[TB] FAIL async_busy: got %b expected 0", bus.busy_wait);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL async_stall: got %0d expected 0", bus.stall_cnt);
    end
    checks++;
    if (bus.mem_timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL async_timeout: got %b expected 0", bus.mem_timeout);
    end
    checks++;
    if (ctl_act !== 7'b1111100) begin
      errors++; $display("[TB] FAIL async_ctl: got %b expected %b", ctl_act, 7'b1111100);
    end
    model_clear();
    @(posedge clk);
    #3;
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_wait !== 1'b0) begin
      errors++; $display("[TB] FAIL async_post_busy: got %b expected 0", bus.busy_wait);
    end
  endtask

  initial begin
    drive_idle();
    model_clear();
    test_reset();
    test_load_use();
    test_x0();
    test_branch_vs_hazard();
    test_mem_wait();
    test_random();
    test_watchdog();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "[TB] time limit exceeded");
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: id_valid  input  1  ID holds a real instruction; id_rs1, id_rs2  input  5 each  ID source registers; id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-004 SHALL have ports: id_rd  input  5  ID destination; id_reg_wen  input  1  ID instruction writes rd.
REQ-005 SHALL have ports: ex_branch_taken  input  1  EX resolved taken branch/jump; mem_req  input  1  MEM stage access active; mem_ready  input  1  memory completes this cycle.
REQ-006 SHALL have ports: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage register load enables.
REQ-007 SHALL have ports: if_id_flush, id_ex_flush  output  1 each  load bubble (zeros) into that register.
REQ-008 SHALL have ports: stall_cnt  output  16  saturating count of non-advancing cycles; mem_timeout  output  1  sticky watchdog flag; busy_wait  output  1  FSM in MEM_WAIT.

Function
REQ-009 SHALL compute all enable/flush outputs combinationally from current inputs and registered state (zero-cycle latency).
REQ-010 SHALL define freeze = mem_req & ~mem_ready; while freeze, all five enables 0, both flushes 0, scoreboard held.
REQ-011 SHALL keep a 3-entry scoreboard {valid, rd[4:0]} for EX, MEM, WB; regfile is not write-through, so WB is checked.
REQ-012 SHALL assert hazard when id_valid and, for rs1 or rs2 with its _used bit set and value != 0, a valid scoreboard entry with rd == rs exists.
REQ-013 SHALL, on hazard with no freeze and no branch: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
REQ-014 SHALL, on ex_branch_taken with no freeze: all enables 1, if_id_flush=1, id_ex_flush=1; branch takes priority over hazard.
REQ-015 SHALL, with no freeze/hazard/branch: all enables 1, flushes 0.
REQ-016 SHALL priority order: freeze > branch > hazard > run.
REQ-017 SHALL on each non-freeze edge shift WB<=MEM, MEM<=EX, EX<={1,id_rd} only if id_valid & id_reg_wen & id_rd!=0 & no hazard & no branch, else EX<=invalid.
REQ-018 SHALL implement FSM RUN/MEM_WAIT: RUN->MEM_WAIT when freeze; MEM_WAIT->RUN on mem_ready or when mem_req drops; busy_wait=1 in MEM_WAIT.
REQ-019 SHALL count consecutive MEM_WAIT cycles in an 8-bit counter, cleared on entering RUN; reaching 255 sets mem_timeout, held until reset.
REQ-020 SHALL increment stall_cnt on every cycle with pc_en=0, saturating at 0xFFFF.
REQ-021 SHALL treat ex_branch_taken during freeze as deferred: no flush until the release cycle, where REQ-014 applies if still asserted.

Reset
REQ-022 SHALL on reset asynchronously clear: FSM to RUN, all scoreboard valid bits 0, wait counter 0, stall_cnt 0, mem_timeout 0.
REQ-023 SHALL, while reset is asserted, drive enables 1, flushes 0, busy_wait 0; reset mid-MEM_WAIT aborts the wait immediately.

Structure
REQ-024 SHALL place FSM state encoding (RUN=0, MEM_WAIT=1), REG_ZERO=5'd0, WAIT_LIMIT=8'd255 and STALL_MAX in shared package pipe_pkg.
REQ-025 SHALL implement the scoreboard as one sub-module hazard_scoreboard (shift, hold, match logic); FSM/counters in the top.

Verification
REQ-026 SHALL test load-use: issue rd=5 wen, next ID rs1=5 used -> hazard 3 cycles (pc_en=0, id_ex_flush=1), release on 4th; stall_cnt=3.
REQ-027 SHALL test x0: write rd=0 then read rs1=0 -> no stall, scoreboard EX invalid.
REQ-028 SHALL test branch vs hazard same cycle: ex_branch_taken=1 and hazard -> pc_en=1, if_id_flush=1, id_ex_flush=1.
REQ-029 SHALL test memory wait: mem_req=1, mem_ready=0 for 4 cycles -> all enables 0, busy_wait=1 cycles 2-5, scoreboard unchanged; mem_ready=1 -> RUN.
REQ-030 SHALL test watchdog: mem_req=1, mem_ready=0 for 256 cycles -> mem_timeout=1, stays 1 after release, cleared only by reset.
REQ-031 SHALL test async reset asserted mid-MEM_WAIT between clock edges -> busy_wait=0, stall_cnt=0 before next edge.
